neuron_acc_stage: RTL and testbench

NEURON_ACC_STAGE -- requirements
Module: neuron_acc_stage

---
 rtl/neuron_acc_stage.sv | 211 +++++++++++++++++++++
 tb/tb_neuron_acc_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_acc_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : neuron_acc_stage
// Purpose  : Two-neuron multiply-accumulate stage. Accepts N_INPUTS in-order
//            (pixel, weight_0, weight_1) samples. Each pixel (unsigned Q0.8) is
//            multiplied by a signed Q8.8 weight per neuron. The product is
//            registered and then summed into a saturating ACC_W-bit
//            accumulator. At the end of an inference the stage adds the bias,
//            applies ReLU, clamps to 0x7FFF and holds the result until the
//            downstream side accepts it.
// Ports    : clk, reset          - clock / synchronous active-high reset
//            start               - one-cycle pulse that begins an inference
//            in_valid, in_index  - sample strobe and its sequence index
//            pixel               - unsigned Q0.8 pixel
//            weight_0, weight_1  - signed Q8.8 weights
//            bias_0, bias_1      - signed Q8.8 biases, latched on start
//            busy, out_valid     - status / result-valid
//            out_ready           - downstream accept
//            act_0, act_1        - Q8.8 ReLU activations (0x0000..0x7FFF)
//            err_index           - sticky out-of-order sample flag
// Revision : 1.0 - initial release
// ============================================================================
module neuron_acc_stage #(
   parameter int N_INPUTS = 784,
   parameter int ACC_W    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [9:0]  in_index,
   input  logic [7:0]  pixel,
   input  logic [15:0] weight_0,
   input  logic [15:0] weight_1,
   input  logic [15:0] bias_0,
   input  logic [15:0] bias_1,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] act_0,
   output logic [15:0] act_1,
   output logic        err_index
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCUM  = 3'd1,
      S_DRAIN  = 3'd2,
      S_FINAL  = 3'd3,
      S_OUTPUT = 3'd4
   } state_t;

   localparam logic [9:0] LAST_IDX = 10'(N_INPUTS - 1);

   state_t                    state_q, state_d;
   logic [9:0]                cnt_q, cnt_d;
   logic [15:0]               bias_0_q, bias_0_d;
   logic [15:0]               bias_1_q, bias_1_d;
   logic [24:0]               prod_0_q, prod_0_d;
   logic [24:0]               prod_1_q, prod_1_d;
   logic                      prod_vld_q, prod_vld_d;
   logic signed [ACC_W-1:0]   acc_0_q, acc_0_d;
   logic signed [ACC_W-1:0]   acc_1_q, acc_1_d;
   logic [15:0]               act_0_q, act_0_d;
   logic [15:0]               act_1_q, act_1_d;
   logic                      err_q, err_d;

   // Saturating add of a 25-bit signed product into the accumulator. The sum
   // is formed one bit wider so that overflow shows up as a disagreement of
   // the two top bits.
   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0] a,
      input logic        [24:0]      p
   );
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {{(ACC_W-24){p[24]}}, p};
      if (s[ACC_W] != s[ACC_W-1]) begin
         sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sat_add = s[ACC_W-1:0];
      end
   endfunction

   // Q8.16 accumulator -> Q8.8, plus bias, then ReLU and clamp to 0x7FFF.
   function automatic logic [15:0] relu_sat(
      input logic signed [ACC_W-1:0] a,
      input logic        [15:0]      b
   );
      logic signed [ACC_W-1:0] sh;
      logic [ACC_W:0]          t;
      sh = a >>> 8;
      t  = {sh[ACC_W-1], sh} + {{(ACC_W-15){b[15]}}, b};
      if (t[ACC_W]) begin
         relu_sat = 16'h0000;
      end else if (|t[ACC_W-1:15]) begin
         relu_sat = 16'h7FFF;
      end else begin
         relu_sat = t[15:0];
      end
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bias_0_d   = bias_0_q;
      bias_1_d   = bias_1_q;
      prod_0_d   = prod_0_q;
      prod_1_d   = prod_1_q;
      prod_vld_d = 1'b0;
      acc_0_d    = acc_0_q;
      acc_1_d    = acc_1_q;
      act_0_d    = act_0_q;
      act_1_d    = act_1_q;
      err_d      = err_q;

      // A product registered last cycle always lands this cycle; this is what
      // lets the final sample drain while the FSM sits in DRAIN.
      if (prod_vld_q) begin
         acc_0_d = sat_add(acc_0_q, prod_0_q);
         acc_1_d = sat_add(acc_1_q, prod_1_q);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_ACCUM;
               bias_0_d = bias_0;
               bias_1_d = bias_1;
               acc_0_d  = '0;
               acc_1_d  = '0;
               cnt_d    = '0;
               err_d    = 1'b0;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               if (in_index == cnt_q) begin
                  prod_vld_d = 1'b1;
                  // Zero-extended pixel times sign-extended weight; the low
                  // 25 bits of the product are exact in two's complement.
                  prod_0_d = {{17{1'b0}}, pixel} * {{9{weight_0[15]}}, weight_0};
                  prod_1_d = {{17{1'b0}}, pixel} * {{9{weight_1[15]}}, weight_1};
                  if (cnt_q == LAST_IDX) begin
                     state_d = S_DRAIN;
                  end else begin
                     cnt_d = cnt_q + 10'd1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_FINAL;
         end
         S_FINAL: begin
            act_0_d = relu_sat(acc_0_q, bias_0_q);
            act_1_d = relu_sat(acc_1_q, bias_1_q);
            state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bias_0_q   <= '0;
         bias_1_q   <= '0;
         prod_0_q   <= '0;
         prod_1_q   <= '0;
         prod_vld_q <= 1'b0;
         acc_0_q    <= '0;
         acc_1_q    <= '0;
         act_0_q    <= '0;
         act_1_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bias_0_q   <= bias_0_d;
         bias_1_q   <= bias_1_d;
         prod_0_q   <= prod_0_d;
         prod_1_q   <= prod_1_d;
         prod_vld_q <= prod_vld_d;
         acc_0_q    <= acc_0_d;
         acc_1_q    <= acc_1_d;
         act_0_q    <= act_0_d;
         act_1_q    <= act_1_d;
         err_q      <= err_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_OUTPUT);
   assign act_0     = act_0_q;
   assign act_1     = act_1_q;
   assign err_index = err_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_acc_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_neuron_acc_stage
// Purpose  : Self-checking bench for neuron_acc_stage. Sample streams are
//            randomised, and a behavioural model computes the expected
//            activations with plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_acc_stage;

   localparam int     N       = 784;
   localparam longint ACC_MAX = (longint'(1) <<< 31) - 1;
   localparam longint ACC_MIN = -(longint'(1) <<< 31);

   logic        clk = 1'b0;
   logic        reset, start, in_valid, out_ready;
   logic [9:0]  in_index;
   logic [7:0]  pixel;
   logic [15:0] weight_0, weight_1, bias_0, bias_1;
   logic        busy, out_valid, err_index;
   logic [15:0] act_0, act_1;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  pix_a [N];
   logic [15:0] w0_a  [N];
   logic [15:0] w1_a  [N];

   always #5 clk = ~clk;

   neuron_acc_stage #(.N_INPUTS(N), .ACC_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_index  (in_index),
      .pixel     (pixel),
      .weight_0  (weight_0),
      .weight_1  (weight_1),
      .bias_0    (bias_0),
      .bias_1    (bias_1),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .act_0     (act_0),
      .act_1     (act_1),
      .err_index (err_index)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clamp(input longint v);
      if (v > ACC_MAX) return ACC_MAX;
      if (v < ACC_MIN) return ACC_MIN;
      return v;
   endfunction

   function automatic logic [15:0] activate(input longint a, input logic [15:0] b);
      longint t;
      t = (a >>> 8) + longint'($signed(b));
      if (t < 0)     return 16'h0000;
      if (t > 32767) return 16'h7FFF;
      return t[15:0];
   endfunction

   task automatic model(input logic [15:0] b0, input logic [15:0] b1,
                        output logic [15:0] e0, output logic [15:0] e1);
      longint a0 = 0;
      longint a1 = 0;
      for (int i = 0; i < N; i++) begin
         a0 = clamp(a0 + longint'(pix_a[i]) * longint'($signed(w0_a[i])));
         a1 = clamp(a1 + longint'(pix_a[i]) * longint'($signed(w1_a[i])));
      end
      e0 = activate(a0, b0);
      e1 = activate(a1, b1);
   endtask

   // 0 zeros, 1 single sample, 2 all-0xFF, 3 full random,
   // 4 accumulator-saturation sweep, 5 small random weights
   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         int r0, r1;
         r0 = int'($urandom_range(0, 128));
         r1 = int'($urandom_range(0, 128));
         case (mode)
            0: begin pix_a[i] = 8'h00; w0_a[i] = 16'($urandom); w1_a[i] = 16'($urandom); end
            1: begin
               pix_a[i] = (i == 0) ? 8'h80 : 8'h00;
               w0_a[i]  = (i == 0) ? 16'h0200 : 16'($urandom);
               w1_a[i]  = 16'($urandom);
            end
            2: begin pix_a[i] = 8'hFF; w0_a[i] = 16'h0100; w1_a[i] = 16'hFF00; end
            3: begin pix_a[i] = 8'($urandom); w0_a[i] = 16'($urandom); w1_a[i] = 16'($urandom); end
            4: begin
               pix_a[i] = 8'hFF;
               w0_a[i]  = (i < 600) ? 16'h7FFF : 16'h8000;
               w1_a[i]  = (i < 600) ? 16'h8000 : 16'h7FFF;
            end
            default: begin pix_a[i] = 8'($urandom); w0_a[i] = 16'(r0 - 64); w1_a[i] = 16'(r1 - 64); end
         endcase
      end
   endtask

   task automatic run(input int gap_pct, input int err_pct, input int err_at,
                      input int abort_at, input int hold, input bit reset_in_out,
                      input logic [15:0] b0, input logic [15:0] b1);
      logic [15:0] e0, e1;
      bit err_exp  = 1'b0;
      bit err_done = 1'b0;
      int idx      = 0;
      int guard    = 0;
      model(b0, b1, e0, e1);
      bias_0 = b0;
      bias_1 = b1;
      start  = 1'b1;
      step();
      start  = 1'b0;
      bias_0 = 16'($urandom);
      bias_1 = 16'($urandom);
      check("busy_after_start", busy, 1);
      check("err_clear_on_start", err_index, 0);

      while (idx < N) begin
         guard++;
         if (guard > 20000) begin
            check("accum_budget", 0, 1);
            break;
         end
         if (idx == abort_at) begin
            reset = 1'b1; start = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_index = 10'(idx);
            step();
            reset = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_ov", out_valid, 0);
            check("abort_act0", act_0, 0);
            check("abort_act1", act_1, 0);
            check("abort_err", err_index, 0);
            for (int k = 0; k < 4; k++) begin
               step();
               check("abort_quiet", out_valid, 0);
            end
            return;
         end
         pixel    = 8'($urandom);
         weight_0 = 16'($urandom);
         weight_1 = 16'($urandom);
         in_index = 10'($urandom);
         if (idx == err_at && !err_done) begin
            in_valid = 1'b1;
            in_index = 10'(idx + 2);
            err_exp  = 1'b1;
            err_done = 1'b1;
            step();
            check("err_set", err_index, 1);
            continue;
         end
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
         end else if (int'($urandom_range(0, 99)) < err_pct) begin
            in_valid = 1'b1;
            in_index = 10'(idx + 1 + int'($urandom_range(0, 200)));
            err_exp  = 1'b1;
         end else begin
            in_valid = 1'b1;
            in_index = 10'(idx);
            pixel    = pix_a[idx];
            weight_0 = w0_a[idx];
            weight_1 = w1_a[idx];
            idx++;
         end
         step();
      end
      in_valid = 1'b0;
      check("drain_ov", out_valid, 0);
      check("err_index", err_index, err_exp);
      step();
      check("final_ov", out_valid, 0);
      step();
      check("out_valid_rise", out_valid, 1);
      check("act_0", act_0, e0);
      check("act_1", act_1, e1);

      if (reset_in_out) begin
         reset = 1'b1; out_ready = 1'b1;
         step();
         reset = 1'b0; out_ready = 1'b0;
         check("rst_out_busy", busy, 0);
         check("rst_out_ov", out_valid, 0);
         check("rst_out_act0", act_0, 0);
         check("rst_out_act1", act_1, 0);
         step();
         check("rst_out_quiet", out_valid, 0);
         return;
      end

      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = 1'($urandom_range(0, 1));
         in_valid  = 1'b1;
         step();
         check("hold_ov", out_valid, 1);
         check("hold_act0", act_0, e0);
         check("hold_act1", act_1, e1);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("hs_ov_drop", out_valid, 0);
      check("hs_idle", busy, 0);
      step();
      check("retain_act0", act_0, e0);
      check("retain_act1", act_1, e1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      in_index = '0; pixel = '0; weight_0 = '0; weight_1 = '0;
      bias_0 = 16'h1234; bias_1 = 16'h4321;
      repeat (3) step();
      reset = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_ov", out_valid, 0);
      check("rst_act0", act_0, 0);
      check("rst_act1", act_1, 0);
      check("rst_err", err_index, 0);
      step();

      fill(0); run(0,  0, -1,  -1, 0, 1'b0, 16'h0100, 16'hFF00);
      fill(1); run(20, 0, -1,  -1, 1, 1'b0, 16'h0080, 16'($urandom));
      fill(2); run(0,  0, -1,  -1, 0, 1'b0, 16'h0000, 16'h0000);
      fill(4); run(10, 0, -1,  -1, 0, 1'b0, 16'h0000, 16'h0000);
      fill(5); run(30, 0, -1,  -1, 5, 1'b0, 16'($urandom_range(0, 511)), 16'(-int'($urandom_range(0, 255))));
      fill(5); run(0,  0,  3,  -1, 1, 1'b0, 16'h0040, 16'h0020);
      fill(5); run(20, 5, -1,  -1, 2, 1'b0, 16'($urandom), 16'($urandom));
      fill(5); run(10, 0, -1, 400, 0, 1'b0, 16'h0100, 16'h0100);
      fill(5); run(10, 0, -1,  -1, 2, 1'b0, 16'h0100, 16'h0100);
      fill(3); run(15, 3, -1,  -1, 1, 1'b0, 16'($urandom), 16'($urandom));
      fill(5); run(5,  0, -1,  -1, 0, 1'b1, 16'h0200, 16'h0010);
      fill(5); run(25, 0, -1,  -1, 3, 1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
